// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake between the PC sequencer (master) and imem (slave).
interface pc_sequencer_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic              imem_ready;

  modport master (output imem_req, imem_addr, input imem_ready);
  modport slave  (input imem_req, imem_addr, output imem_ready);
endinterface

// File: rtl/pc_sequencer.sv
// Program counter owner and fetch sequencer: redirect arbitration, imem handshake, flush strobes.
// Optional interrupt redirect is compiled in with `define PC_SEQ_IRQ_EN.
module pc_sequencer #(
  parameter int              ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(32'h0000_0010)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              halt,
  input  logic              branch_en,
  input  logic [3:0]        branch_cond,
  input  logic [3:0]        alu_flag,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_target,
  pc_sequencer_if.master    imem,
  output logic [ADDR_W-1:0] pc_out,
  output logic              flush_if,
  output logic              flush_id,
  output logic              halted,
  input  logic              irq,
  output logic              irq_ack
);

  localparam logic [1:0] ST_BOOT   = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] pc;
  logic              pend_v;
  logic              pend_br;
  logic [ADDR_W-1:0] pend_addr;

  logic              taken;
  logic              accept;
  logic [ADDR_W-1:0] pc_nxt;
  logic              redirect;
  logic              redirect_br;

  assign taken          = branch_en && (alu_flag == branch_cond);
  assign accept         = (state == ST_FETCH) && imem.imem_ready;
  assign imem.imem_req  = (state == ST_FETCH);
  assign imem.imem_addr = pc;
  assign pc_out         = pc;
  assign halted         = (state == ST_HALTED);

  // NOTE: every output of this block gets a default first so no path infers a latch.
  always_comb begin
    pc_nxt      = pc;
    redirect    = 1'b0;
    redirect_br = 1'b0;
    if (pend_v) begin
      pc_nxt      = pend_addr;
      redirect    = 1'b1;
      redirect_br = pend_br;
    end else if (taken) begin
      pc_nxt      = branch_target;
      redirect    = 1'b1;
      redirect_br = 1'b1;
    end else if (jump_en) begin
      pc_nxt   = jump_target;
      redirect = 1'b1;
    end else if (!stall) begin
      pc_nxt = pc + ADDR_W'(1);
    end
`ifdef PC_SEQ_IRQ_EN
    if (irq) begin
      pc_nxt      = IRQ_VEC;
      redirect    = 1'b1;
      redirect_br = 1'b1;
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_BOOT;
      pc       <= RESET_VEC;
      pend_v   <= 1'b0;
      pend_br  <= 1'b0;
      flush_if <= 1'b0;
      flush_id <= 1'b0;
    end else begin
      flush_if <= 1'b0;
      flush_id <= 1'b0;
      case (state)
        ST_BOOT: state <= ST_FETCH;
        ST_FETCH: begin
          if (accept) begin
            pc       <= pc_nxt;
            pend_v   <= 1'b0;
            flush_if <= redirect;
            flush_id <= redirect_br;
            if (halt) state <= ST_HALTED;
          end else if (taken) begin
            // A newer branch always replaces whatever is pending.
            pend_v  <= 1'b1;
            pend_br <= 1'b1;
          end else if (jump_en && !(pend_v && pend_br)) begin
            pend_v  <= 1'b1;
            pend_br <= 1'b0;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_BOOT;
      endcase
    end
  end

  // NOTE: pend_addr is only ever read while pend_v is set, so it carries no reset.
  always_ff @(posedge clk) begin
    if (state == ST_FETCH && !accept) begin
      if (taken)
        pend_addr <= branch_target;
      else if (jump_en && !(pend_v && pend_br))
        pend_addr <= jump_target;
    end
  end

`ifdef PC_SEQ_IRQ_EN
  always_ff @(posedge clk) begin
    if (reset) irq_ack <= 1'b0;
    else       irq_ack <= accept && irq;
  end
`else
  logic [ADDR_W:0] unused_irq_sink;
  assign unused_irq_sink = {irq, IRQ_VEC};
  assign irq_ack         = 1'b0;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential fetch, branch/jump redirect, pend, stall, wrap, halt, irq.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        reset;
  logic        stall, halt, branch_en, jump_en, irq;
  logic [3:0]  branch_cond, alu_flag;
  logic [31:0] branch_target, jump_target;
  logic [31:0] pc_out;
  logic        flush_if, flush_id, halted, irq_ack;

  int n_asserts = 0;
  int n_fail    = 0;

  pc_sequencer_if #(.ADDR_W(32)) imem_bus ();

  pc_sequencer #(.ADDR_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .stall         (stall),
    .halt          (halt),
    .branch_en     (branch_en),
    .branch_cond   (branch_cond),
    .alu_flag      (alu_flag),
    .branch_target (branch_target),
    .jump_en       (jump_en),
    .jump_target   (jump_target),
    .imem          (imem_bus),
    .pc_out        (pc_out),
    .flush_if      (flush_if),
    .flush_id      (flush_id),
    .halted        (halted),
    .irq           (irq),
    .irq_ack       (irq_ack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_asserts++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    stall = 0; halt = 0; branch_en = 0; jump_en = 0; irq = 0;
    branch_cond = 4'h0; alu_flag = 4'h0;
    branch_target = 32'h0; jump_target = 32'h0;
    imem_bus.imem_ready = 1'b1;
  endtask

  // Reset, then advance with imem always ready until pc reaches n.
  task automatic restart(input int n);
    clear_inputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i <= n; i++) step();
    check("restart_pc", pc_out, 32'(n));
  endtask

  initial begin
    clear_inputs();
    reset = 1'b1;
    step();
    check("rst_pc", pc_out, 32'h0);
    check("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    check("rst_flush_if", {31'b0, flush_if}, 32'h0);
    check("rst_flush_id", {31'b0, flush_id}, 32'h0);
    check("rst_halted", {31'b0, halted}, 32'h0);
    check("rst_irq_ack", {31'b0, irq_ack}, 32'h0);
    reset = 1'b0;

    // Cycle 1 is BOOT; cycles 2..5 fetch 0,1,2,3.
    check("boot_addr", imem_bus.imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step();
      check("seq_addr", imem_bus.imem_addr, 32'(i));
      check("seq_req", {31'b0, imem_bus.imem_req}, 32'h1);
      check("seq_flush", {30'b0, flush_if, flush_id}, 32'h0);
    end
    step(); step();
    check("at_pc5", pc_out, 32'h5);

    // Taken branch at pc=5.
    branch_en = 1; branch_cond = 4'b0100; alu_flag = 4'b0100; branch_target = 32'h40;
    step();
    branch_en = 0;
    check("br_pc", pc_out, 32'h40);
    check("br_flush", {30'b0, flush_if, flush_id}, 32'h3);
    step();
    check("br_after_pc", pc_out, 32'h41);
    check("br_after_flush", {30'b0, flush_if, flush_id}, 32'h0);

    // Same branch, flags mismatch: sequential, no flush.
    restart(5);
    branch_en = 1; branch_cond = 4'b0100; alu_flag = 4'b0010; branch_target = 32'h40;
    step();
    branch_en = 0;
    check("nt_pc", pc_out, 32'h6);
    check("nt_flush", {30'b0, flush_if, flush_id}, 32'h0);

    // Jump while imem not ready for 3 cycles: held, then applied from pend.
    imem_bus.imem_ready = 0; jump_en = 1; jump_target = 32'h80;
    step();
    jump_en = 0;
    check("pend_hold1", imem_bus.imem_addr, 32'h6);
    step();
    check("pend_hold2", imem_bus.imem_addr, 32'h6);
    step();
    check("pend_hold3", imem_bus.imem_addr, 32'h6);
    check("pend_req", {31'b0, imem_bus.imem_req}, 32'h1);
    imem_bus.imem_ready = 1;
    step();
    check("pend_pc", pc_out, 32'h80);
    check("pend_flush", {30'b0, flush_if, flush_id}, 32'h2);

    // Pending branch is not overwritten by a later jump.
    imem_bus.imem_ready = 0;
    branch_en = 1; branch_cond = 4'hA; alu_flag = 4'hA; branch_target = 32'h200;
    step();
    branch_en = 0; jump_en = 1; jump_target = 32'h300;
    step();
    jump_en = 0; imem_bus.imem_ready = 1;
    step();
    check("pend_br_keep_pc", pc_out, 32'h200);
    check("pend_br_flush", {30'b0, flush_if, flush_id}, 32'h3);

    // Reset mid-handshake drops the pending jump.
    restart(2);
    imem_bus.imem_ready = 0; jump_en = 1; jump_target = 32'h80;
    step();
    jump_en = 0; reset = 1;
    step();
    reset = 0; imem_bus.imem_ready = 1;
    step(); step();
    check("rst_drop_pend", pc_out, 32'h1);

    // Stall holds pc=9; a taken branch during the stall still redirects.
    restart(9);
    stall = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_addr", imem_bus.imem_addr, 32'h9);
    end
    branch_en = 1; branch_cond = 4'h3; alu_flag = 4'h3; branch_target = 32'h55;
    step();
    branch_en = 0; stall = 0;
    check("stall_br_pc", pc_out, 32'h55);
    step();
    check("stall_release", pc_out, 32'h56);

    // Wrap at all-ones, then halt.
    jump_en = 1; jump_target = 32'hFFFF_FFFF;
    step();
    jump_en = 0;
    check("wrap_pre", pc_out, 32'hFFFF_FFFF);
    step();
    check("wrap_pc", pc_out, 32'h0);
    halt = 1;
    step();
    halt = 0;
    check("halted", {31'b0, halted}, 32'h1);
    check("halt_req", {31'b0, imem_bus.imem_req}, 32'h0);
    step(); step(); step();
    check("halted_stay", {31'b0, halted}, 32'h1);
    check("halt_req_stay", {31'b0, imem_bus.imem_req}, 32'h0);

    // Interrupt racing a taken branch.
    restart(3);
    irq = 1; branch_en = 1; branch_cond = 4'h5; alu_flag = 4'h5; branch_target = 32'h40;
    step();
    irq = 0; branch_en = 0;
`ifdef PC_SEQ_IRQ_EN
    check("irq_pc", pc_out, 32'h10);
    check("irq_ack", {31'b0, irq_ack}, 32'h1);
    check("irq_flush", {30'b0, flush_if, flush_id}, 32'h3);
    step();
    check("irq_ack_pulse", {31'b0, irq_ack}, 32'h0);
    check("irq_after_pc", pc_out, 32'h11);
`else
    check("noirq_pc", pc_out, 32'h40);
    check("noirq_ack", {31'b0, irq_ack}, 32'h0);
    step();
    check("noirq_ack2", {31'b0, irq_ack}, 32'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
